// File: rtl/mdu_div_iter_pkg.sv
// rtl/mdu_div_iter_pkg.sv - shared state encoding and width for the iterative divider
package mdu_div_iter_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/mdu_div_iter_div.sv
// rtl/mdu_div_iter_div.sv - one combinational restoring-division step
module div_iter
  import mdu_div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dvd_out,
  output logic             q_bit
);

  // Shifted partial remainder is one bit wider so the compare cannot overflow.
  logic [WIDTH:0] shifted;

  // Shift in the next dividend bit, compare, and conditionally subtract.
  always_comb begin
    shifted = {rem_in, dvd_in[WIDTH-1]};
    q_bit   = (shifted >= {1'b0, divisor});
    // When q_bit is set the true difference is below 2^WIDTH, so modulo
    // WIDTH-bit subtraction gives the exact remainder.
    rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    // Quotient bits accumulate into the low end as dividend bits leave the top.
    dvd_out = {dvd_in[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - multi-cycle radix-2 restoring DIV/DIVU unit for the E stage
module mdu_div_iter
  import mdu_div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             e_ena,
  input  logic             flush,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic [WIDTH-1:0] rem_nx, dvd_nx;
  logic             q_bit;

  div_iter #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_in  (dvd_q),
    .divisor (dvs_q),
    .rem_out (rem_nx),
    .dvd_out (dvd_nx),
    .q_bit   (q_bit)
  );

  // Stall until DONE; a held reset must never stall the pipeline.
  always_comb begin
    stall        = resetn & start & (state_q != DONE);
    result_valid = (state_q == DONE);
    result_lo    = lo_q;
    result_hi    = hi_q;
  end

  // Next-state, operand capture, iteration and sign fixup.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = BUSY;
            cnt_d   = '0;
            rem_d   = '0;
            // Negating 0x80000000 yields 0x80000000, which is the correct
            // unsigned magnitude 2^(WIDTH-1).
            dvd_d   = (is_signed && a[WIDTH-1]) ? -a : a;
            dvs_d   = (is_signed && b[WIDTH-1]) ? -b : b;
            neg_q_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_d = is_signed & a[WIDTH-1];
          end
        end
        BUSY: begin
          if (!start) begin
            state_d = IDLE;
          end else begin
            rem_d = rem_nx;
            dvd_d = dvd_nx;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              lo_d    = neg_q_q ? -dvd_nx : dvd_nx;
              hi_d    = neg_r_q ? -rem_nx : rem_nx;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (e_ena) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_mdu_div_iter.sv
// tb/tb_mdu_div_iter.sv - directed self-checking bench for mdu_div_iter
module tb_mdu_div_iter;

  logic        clk = 1'b0;
  logic        resetn, e_ena, flush, start, is_signed;
  logic [31:0] a, b;
  logic        stall, result_valid;
  logic [31:0] result_lo, result_hi;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mdu_div_iter dut (
    .clk          (clk),
    .resetn       (resetn),
    .e_ena        (e_ena),
    .flush        (flush),
    .start        (start),
    .is_signed    (is_signed),
    .a            (a),
    .b            (b),
    .stall        (stall),
    .result_valid (result_valid),
    .result_lo    (result_lo),
    .result_hi    (result_hi)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        chk_val;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called just after a rising edge; drives a new divide request.
  task automatic issue(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
    start     = 1'b1;
    is_signed = sgn;
    a         = av;
    b         = bv;
  endtask

  // Counts stall-high cycles (sampled on falling edges) until stall drops.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) n++;
      else return;
    end
  endtask

  // Lets the instruction leave E, then confirms result_valid dropped.
  task automatic release_e(input string name);
    e_ena = 1'b1;
    @(posedge clk);
    #1;
    e_ena = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check({name, " valid_drop"}, {31'd0, result_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];
  int   n;

  initial begin
    vecs[0] = '{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b1};
    vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b1};
    vecs[2] = '{"div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'h00000001,   1'b1};
    vecs[3] = '{"div_ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h00000000,   1'b1};
    vecs[4] = '{"divu_by0",     1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1};
    vecs[5] = '{"div_by0",      1'b1, 32'hFFFFFF00,   32'd0,          32'd0,          32'd0,          1'b0};
    vecs[6] = '{"divu_max_3",   1'b0, 32'hFFFFFFFF,   32'd3,          32'h55555555,   32'd0,          1'b1};

    resetn = 1'b0; e_ena = 1'b0; flush = 1'b0; start = 1'b1;
    is_signed = 1'b0; a = 32'd5; b = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset valid", {31'd0, result_valid}, 32'd0);
    check("reset lo", result_lo, 32'd0);
    check("reset hi", result_hi, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven divides, each with e_ena following ~stall.
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(n);
      check({vecs[i].name, " latency"}, n, 32'd33);
      check({vecs[i].name, " valid"}, {31'd0, result_valid}, 32'd1);
      if (vecs[i].chk_val) begin
        check({vecs[i].name, " lo"}, result_lo, vecs[i].lo);
        check({vecs[i].name, " hi"}, result_hi, vecs[i].hi);
      end
      release_e(vecs[i].name);
    end

    // Hold in DONE with e_ena low, then back-to-back second divide.
    issue(1'b0, 32'd20, 32'd3);
    wait_done(n);
    check("hold latency", n, 32'd33);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("hold stall", {31'd0, stall}, 32'd0);
      check("hold valid", {31'd0, result_valid}, 32'd1);
      check("hold lo", result_lo, 32'd6);
      check("hold hi", result_hi, 32'd2);
    end
    e_ena = 1'b1;
    @(posedge clk);
    #1;
    e_ena = 1'b0;
    issue(1'b0, 32'd9, 32'd4);
    wait_done(n);
    check("b2b latency", n, 32'd33);
    check("b2b lo", result_lo, 32'd2);
    check("b2b hi", result_hi, 32'd1);
    release_e("b2b");

    // Flush on BUSY cycle 10 with start dropped.
    issue(1'b0, 32'd1000, 32'd3);
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush stall", {31'd0, stall}, 32'd0);
    check("flush valid", {31'd0, result_valid}, 32'd0);
    @(posedge clk);
    #1;
    issue(1'b0, 32'd1000, 32'd3);
    wait_done(n);
    check("post_flush latency", n, 32'd33);
    check("post_flush lo", result_lo, 32'd333);
    check("post_flush hi", result_hi, 32'd1);
    release_e("post_flush");

    // Reset on BUSY cycle 5 abandons the divide and clears results.
    issue(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset stall", {31'd0, stall}, 32'd0);
    check("midreset valid", {31'd0, result_valid}, 32'd0);
    check("midreset lo", result_lo, 32'd0);
    check("midreset hi", result_hi, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    issue(1'b0, 32'd50, 32'd5);
    wait_done(n);
    check("post_reset latency", n, 32'd33);
    check("post_reset lo", result_lo, 32'd10);
    check("post_reset hi", result_hi, 32'd0);
    release_e("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mdu_div_iter.md
Name: mdu_div_iter

Overview:
- Multi-cycle radix-2 restoring integer divider for DIV/DIVU, placed in the E stage beside the ALU.
- Producer side of the E-stage ALU stall handshake. Its `stall` output drives the hazard unit's `E_alu_stall` input.
- It consumes the hazard unit's E-stage enable and the M-stage exception flush.
- Quotient goes to LO and remainder to HI. Results are held until the E stage advances.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  core clock. All state updates on the rising edge.
- resetn  in  1  synchronous reset, active-low.
- e_ena  in  1  E-stage enable from the hazard unit. 1 means the E-stage instruction advances this cycle.
- flush  in  1  E-stage flush (M-stage exception). Aborts any division in flight.
- start  in  1  the E-stage instruction is DIV/DIVU. Held high until the instruction leaves E.
- is_signed  in  1  1 selects DIV, 0 selects DIVU. Sampled on the start cycle.
- a  in  WIDTH  dividend. Sampled on the start cycle.
- b  in  WIDTH  divisor. Sampled on the start cycle.
- stall  out  1  division incomplete; drives E_alu_stall.
- result_valid  out  1  high in DONE.
- result_lo  out  WIDTH  quotient.
- result_hi  out  WIDTH  remainder.

Behaviour:
- Reset (resetn=0 at an edge):
  - state becomes IDLE; counter, quotient/remainder registers and result_hi/result_lo become 0.
  - stall = 0 combinationally while resetn=0.
  - Reset mid-operation abandons the operation; there is no partial result.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If start=1 and flush=0: latch |a|, |b| (absolute values only when is_signed=1), sign_q = a[W-1]^b[W-1], sign_r = a[W-1], counter=0, then go to BUSY.
  - Otherwise remain in IDLE.
- BUSY, one quotient bit per cycle, MSB first:
  - Shift {rem,dvd} left by 1.
  - If rem >= divisor: subtract and set the quotient bit to 1; else set it to 0.
  - counter increments each cycle.
  - On the cycle with counter == WIDTH-1: apply sign fixup (negate quotient if signed & sign_q; negate remainder if signed & sign_r), load result_lo/result_hi, then go to DONE.
- DONE:
  - result_valid=1.
  - Results stay stable while e_ena=0.
  - If e_ena=1: go to IDLE.
- stall = resetn & start & (state != DONE).
  - stall is high on the start cycle and for all WIDTH BUSY cycles: WIDTH+1 = 33 cycles total.
  - It is low in the first DONE cycle, which is the cycle the instruction may advance.
- Back-to-back divides: the DONE→IDLE edge is followed by IDLE sampling the next start. A new divide begins one cycle after the prior one leaves E.
- flush:
  - Has priority over start and over everything except reset.
  - In any state, flush=1 at an edge forces IDLE and discards results.
  - stall follows start, which is low after the flush.
- start dropping to 0 while in BUSY: abort to IDLE on the next edge. This is defensive only; a well-formed pipeline never does it.
- e_ena=1 while in BUSY cannot occur, because stall holds the E stage. It is ignored.
- Divide by zero:
  - No trap; latency is unchanged.
  - Unsigned: quotient = all-ones, remainder = a.
  - Signed: the magnitude result with sign fixup applied. The value is architecturally unpredictable, so only latency and release are checked.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0.
- Arithmetic: the remainder datapath is WIDTH+1 bits wide so the compare does not overflow. Negation is two's complement.

Decomposition:
- Shared package: the div_state_t enum (IDLE, BUSY, DONE) and the DIV_WIDTH constant (32).
- One sub-module, div_iter: combinational single iteration, {rem_in, dvd_in, divisor} -> {rem_out, dvd_out, q_bit}. Unit-testable in isolation.
- The FSM, counter and sign fixup stay in mdu_div_iter.

Test Plan:
- DIVU 100/7 with e_ena tied to ~stall -> stall high exactly 33 cycles; DONE gives lo=14 (0x0000000E), hi=2; result_valid high 1 cycle.
- DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 20/3 with e_ena forced 0 for 5 cycles after DONE -> stall=0, result_valid=1, lo=6, hi=2 stable; e_ena=1 -> IDLE; immediate second start DIVU 9/4 -> lo=2, hi=1 after 33 stall cycles.
- Start DIVU 1000/3, assert flush on BUSY cycle 10 with start dropped -> IDLE next cycle, stall=0. A following DIVU 1000/3 completes with lo=333, hi=1 and full 33-cycle latency.
- DIVU 0x1234/0 -> 33-cycle stall, then lo=0xFFFFFFFF, hi=0x1234.
- resetn=0 on BUSY cycle 5 -> state IDLE, stall=0, result_lo/hi=0. After release, DIVU 50/5 -> lo=10, hi=0.
